// File: rtl/regfile_pkg.sv
// Shared constants and lane-slicing helper for the register file and its scoreboard.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_IDX       = 0;

    // Base bit of lane k in a flat bus of k lanes each w bits wide
    // (used both to pack outputs and to unpack inputs).
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers claimed by issue until writeback clears them.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_rdy,
    input  logic                     flush
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic             iss_fixed;
    logic             iss_wr_hit;

    assign iss_fixed  = (ZERO_REG != 0) && (iss_addr == ADDR_W'(ZERO_IDX));
    assign iss_wr_hit = wr_en && (wr_addr == iss_addr);
    assign iss_rdy    = !busy_reg[iss_addr] || iss_wr_hit || iss_fixed;

    // Issue is applied after writeback so a same-register claim wins.
    always_comb begin
        busy_next = busy_reg;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_en)
                busy_next[wr_addr] = 1'b0;
            if (iss_en && iss_rdy && !iss_fixed)
                busy_next[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_busy
            logic [ADDR_W-1:0] addr;
            logic              fixed;
            logic              resolving;
            assign addr      = rd_addr[lane_lo(gi, ADDR_W) +: ADDR_W];
            assign fixed     = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_IDX));
            assign resolving = (BYPASS != 0) && wr_en && (wr_addr == addr);
            assign rd_busy[gi] = busy_reg[addr] && !resolving && !fixed;
        end
    endgenerate

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports, write-through bypass and scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic                     iss_rdy_o,
    input  logic                     flush_i
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              wr_fixed;

    assign wr_fixed = (ZERO_REG != 0) && (wr_addr_i == ADDR_W'(ZERO_IDX));

    // Storage is cleared by reset, so it is built from flops rather than block RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (wr_en_i && !wr_fixed) begin
            mem_reg[wr_addr_i] <= wr_data_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              fixed;
            logic              fwd;
            assign addr  = rd_addr_i[lane_lo(gi, ADDR_W) +: ADDR_W];
            assign fixed = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_IDX));
            assign fwd   = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr);
            assign rd_data_o[lane_lo(gi, DATA_W) +: DATA_W] =
                fixed ? '0 : (fwd ? wr_data_i : mem_reg[addr]);
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk_i),
        .rst      (rst_i),
        .rd_addr  (rd_addr_i),
        .rd_busy  (rd_busy_o),
        .wr_en    (wr_en_i),
        .wr_addr  (wr_addr_i),
        .iss_en   (iss_en_i),
        .iss_addr (iss_addr_i),
        .iss_rdy  (iss_rdy_o),
        .flush    (flush_i)
    );

endmodule
